atmos_light_est: RTL and testbench

- Statistics stage directly downstream of the dark-channel stage in the haze-removal pipeline.
- Consumes the 8-bit dark-channel stream together with the delay-aligned 24-bit RGB source stream.
- Each frame, finds the pixel with the brightest dark-channel value and derives atmospheric light A from that pixel's RGB.
- A is held stable for the whole next frame, where the transmission-estimation and recovery stages use it as a sideband constant.

---
 rtl/atmos_light_est_pkg.sv | 33 +++
 rtl/atmos_light_est_max3.sv | 17 +
 rtl/atmos_light_est.sv | 101 ++++++++++
 tb/tb_atmos_light_est.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/atmos_light_est_pkg.sv
// Shared haze-pipeline constants: pixel width, RGB field positions and default A limits.
// Also holds the A floor clamp and the 3:1 IIR step used by atmos_light_est (ATMOS_IIR_EN).
package atmos_light_est_pkg;

    localparam int PIX_W = 8;
    localparam int RGB_W = 3 * PIX_W;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    localparam logic [PIX_W-1:0] A_INIT_DEF  = 8'd255;
    localparam logic [PIX_W-1:0] A_FLOOR_DEF = 8'd8;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    function automatic logic [PIX_W-1:0] floor_clamp(input logic [PIX_W-1:0] v,
                                                     input logic [PIX_W-1:0] fl);
        return (v < fl) ? fl : v;
    endfunction

    // (3*old + new) >> 2; the worst case 1020 fits the 10-bit accumulator.
    function automatic logic [PIX_W-1:0] iir_step(input logic [PIX_W-1:0] a_old,
                                                  input logic [PIX_W-1:0] a_frame);
        logic [PIX_W+1:0] acc;
        acc = ({2'b00, a_old} << 1) + {2'b00, a_old} + {2'b00, a_frame};
        return acc[PIX_W+1:2];
    endfunction

endpackage

// File: rtl/atmos_light_est_max3.sv
// Combinational maximum of three unsigned 8-bit channels (module max3_u8).
// Shared with the recovery stage.
module max3_u8
    import atmos_light_est_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    input  logic [PIX_W-1:0] c,
    output logic [PIX_W-1:0] y
);

    logic [PIX_W-1:0] ab;

    assign ab = (a > b) ? a : b;
    assign y  = (ab > c) ? ab : c;

endmodule

// File: rtl/atmos_light_est.sv
// Atmospheric light estimator: tracks the brightest dark-channel pixel per frame and
// publishes A for the next frame. Define ATMOS_IIR_EN to temporally smooth A.
module atmos_light_est
    import atmos_light_est_pkg::*;
#(
    parameter logic [PIX_W-1:0] A_FLOOR = A_FLOOR_DEF,
    parameter logic [PIX_W-1:0] A_INIT  = A_INIT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pre_frame_vsync,
    input  logic             pre_frame_href,
    input  logic             pre_frame_clken,
    input  logic [PIX_W-1:0] pre_dark,
    input  logic [RGB_W-1:0] pre_rgb,
    output logic [PIX_W-1:0] atmos_light,
    output logic [RGB_W-1:0] atmos_rgb,
    output logic [PIX_W-1:0] atmos_dark_max,
    output logic             atmos_valid,
    output logic             frame_done
);

    logic             vsync_d;
    logic             pv;
    logic             rise;
    logic             fall;
    logic [PIX_W-1:0] run_max;
    logic [RGB_W-1:0] run_rgb;
    logic             seen;
    rgb_t             run_pix;
    logic [PIX_W-1:0] run_chan_max;
    logic [PIX_W-1:0] a_frame;
    logic [PIX_W-1:0] a_next;

    assign pv   = pre_frame_vsync & pre_frame_href & pre_frame_clken;
    assign rise = pre_frame_vsync & ~vsync_d;
    assign fall = ~pre_frame_vsync & vsync_d;

    assign run_pix = run_rgb;

    max3_u8 u_max3 (
        .a (run_pix.r),
        .b (run_pix.g),
        .c (run_pix.b),
        .y (run_chan_max)
    );

    assign a_frame = floor_clamp(run_chan_max, A_FLOOR);

`ifdef ATMOS_IIR_EN
    // atmos_valid doubles as "history exists": the first measured frame loads directly.
    assign a_next = atmos_valid ? iir_step(atmos_light, a_frame) : a_frame;
`else
    assign a_next = a_frame;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= pre_frame_vsync;
        end
    end

    // Running maximum; strict compare keeps the first pixel in raster order on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max <= '0;
            run_rgb <= '0;
            seen    <= 1'b0;
        end else if (rise) begin
            run_max <= pv ? pre_dark : '0;
            run_rgb <= pv ? pre_rgb : '0;
            seen    <= pv;
        end else if (pv && ((pre_dark > run_max) || !seen)) begin
            run_max <= pre_dark;
            run_rgb <= pre_rgb;
            seen    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atmos_light    <= A_INIT;
            atmos_rgb      <= '1;
            atmos_dark_max <= '0;
            atmos_valid    <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (fall && seen) begin
                atmos_dark_max <= run_max;
                atmos_rgb      <= run_rgb;
                atmos_light    <= a_next;
                atmos_valid    <= 1'b1;
                frame_done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_atmos_light_est.sv
// Directed bench for atmos_light_est: 4x4 frames from a vector table plus hand-written
// sequences for empty frames, one-cycle vsync, stray pixels and mid-frame reset.
module tb_atmos_light_est;
    import atmos_light_est_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs    = 1'b0;
    logic        hr    = 1'b0;
    logic        ce    = 1'b0;
    logic [7:0]  dark  = '0;
    logic [23:0] rgb   = '0;

    logic [7:0]  atmos_light;
    logic [23:0] atmos_rgb;
    logic [7:0]  atmos_dark_max;
    logic        atmos_valid;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_light;
    logic [23:0] model_rgb;
    logic [7:0]  model_dark;
    logic        model_valid;

    typedef struct {
        bit          lead_idle;
        logic [7:0]  base_dark;
        logic [23:0] base_rgb;
        int          idx1;
        logic [7:0]  dark1;
        logic [23:0] rgb1;
        int          idx2;
        logic [7:0]  dark2;
        logic [23:0] rgb2;
        logic [7:0]  exp_dark;
        logic [23:0] exp_rgb;
        logic [7:0]  exp_af;
    } frame_vec_t;

    frame_vec_t vecs [8];

    atmos_light_est dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pre_frame_vsync (vs),
        .pre_frame_href  (hr),
        .pre_frame_clken (ce),
        .pre_dark        (dark),
        .pre_rgb         (rgb),
        .atmos_light     (atmos_light),
        .atmos_rgb       (atmos_rgb),
        .atmos_dark_max  (atmos_dark_max),
        .atmos_valid     (atmos_valid),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic h, input logic c,
                                 input logic [7:0] d, input logic [23:0] p);
        vs   = v;
        hr   = h;
        ce   = c;
        dark = d;
        rgb  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic done_exp);
        checkOutput({tag, ".light"}, {24'd0, atmos_light}, {24'd0, model_light});
        checkOutput({tag, ".rgb"}, {8'd0, atmos_rgb}, {8'd0, model_rgb});
        checkOutput({tag, ".dark_max"}, {24'd0, atmos_dark_max}, {24'd0, model_dark});
        checkOutput({tag, ".valid"}, {31'd0, atmos_valid}, {31'd0, model_valid});
        checkOutput({tag, ".done"}, {31'd0, frame_done}, {31'd0, done_exp});
    endtask

    task automatic modelUpdate(input logic [7:0] d, input logic [23:0] p, input logic [7:0] af);
        model_dark = d;
        model_rgb  = p;
`ifdef ATMOS_IIR_EN
        model_light = model_valid ? 8'(((32'(model_light) * 3) + 32'(af)) / 4) : af;
`else
        model_light = af;
`endif
        model_valid = 1'b1;
    endtask

    task automatic modelReset();
        model_light = 8'd255;
        model_rgb   = 24'hFFFFFF;
        model_dark  = 8'd0;
        model_valid = 1'b0;
    endtask

    task automatic runFrame(input int n, input frame_vec_t v);
        string tag;
        logic [7:0]  d;
        logic [23:0] p;
        tag = $sformatf("vec%0d", n);
        if (v.lead_idle) applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 24'd0);
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                d = v.base_dark;
                p = v.base_rgb;
                if (row * 4 + col == v.idx1) begin d = v.dark1; p = v.rgb1; end
                if (row * 4 + col == v.idx2) begin d = v.dark2; p = v.rgb2; end
                applyStimulus(1'b1, 1'b1, 1'b1, d, p);
            end
            applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 24'hFFFFFF);
            applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 24'd0);
        end
        checkAll({tag, ".hold"}, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        modelUpdate(v.exp_dark, v.exp_rgb, v.exp_af);
        checkAll({tag, ".end"}, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkOutput({tag, ".done_clear"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1, 8'd10, 24'h101010, 9, 8'd200, 24'h50A030, -1, 8'd0, 24'd0,
                    8'd200, 24'h50A030, 8'hA0};
        vecs[1] = '{1, 8'd10, 24'h101010, 3, 8'd150, 24'h111111, 12, 8'd150, 24'h222222,
                    8'd150, 24'h111111, 8'h11};
        vecs[2] = '{1, 8'd5, 24'h010101, 6, 8'd100, 24'h030201, -1, 8'd0, 24'd0,
                    8'd100, 24'h030201, 8'd8};
        vecs[3] = '{1, 8'd5, 24'h010101, 15, 8'd100, 24'h0A0B0C, -1, 8'd0, 24'd0,
                    8'd100, 24'h0A0B0C, 8'h0C};
        vecs[4] = '{0, 8'd50, 24'h202020, 0, 8'd240, 24'h3C7896, -1, 8'd0, 24'd0,
                    8'd240, 24'h3C7896, 8'h96};
        vecs[5] = '{1, 8'd20, 24'h000000, 10, 8'd90, 24'hB41020, -1, 8'd0, 24'd0,
                    8'd90, 24'hB41020, 8'd180};
        vecs[6] = '{1, 8'd30, 24'h050505, 5, 8'd90, 24'hC80000, -1, 8'd0, 24'd0,
                    8'd90, 24'hC80000, 8'd200};
        vecs[7] = '{1, 8'd30, 24'h050505, 14, 8'd80, 24'h006400, -1, 8'd0, 24'd0,
                    8'd80, 24'h006400, 8'd100};

        modelReset();
        #12;
        checkAll("reset", 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkAll("post_reset", 1'b0);

        for (int i = 0; i < 6; i++) runFrame(i, vecs[i]);

        // Empty frame: href toggles but no clken, so nothing is measured.
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, i[0], 1'b0, 8'hFF, 24'hFFFFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkAll("empty.end", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkAll("empty.after", 1'b0);

        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF, 24'hFFFFFF);
        checkAll("stray_pv", 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, 8'd77, 24'h4D0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        modelUpdate(8'd77, 24'h4D0000, 8'h4D);
        checkAll("pulse.end", 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkAll("pulse.after", 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 24'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd250, 24'hFAFAFA);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd20, 24'h101010);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("midreset", 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkAll("midreset.release", 1'b0);

        for (int i = 6; i < 8; i++) runFrame(i, vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
